// File: rtl/ram_scan_pkg.sv
// -----------------------------------------------------------------------------
// ram_scan_pkg
// Shared definitions for the RAM scan controller:
//   - mode encodings carried on the 2-bit mode input
//   - FSM state encodings (legacy-compatible localparam constants)
//   - a helper that maps a start command's mode to the state it launches
// No ports; imported by ram_scan_ctrl.
// -----------------------------------------------------------------------------
package ram_scan_pkg;

    typedef logic [1:0] mode_t;
    typedef logic [1:0] state_t;

    // Command modes, sampled only together with start while idle
    localparam mode_t MODE_MANUAL = 2'b00;
    localparam mode_t MODE_CLEAR  = 2'b01;
    localparam mode_t MODE_SCAN   = 2'b10;
    localparam mode_t MODE_RSVD   = 2'b11;

    // Controller states
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_CLEAR = 2'd1;
    localparam state_t ST_SCAN  = 2'd2;

    // State entered from IDLE when start is seen with the given mode.
    // Manual and reserved modes do not launch anything, so they map to IDLE.
    function automatic state_t start_target(input mode_t mode);
        state_t nxt;
        case (mode)
            MODE_CLEAR: nxt = ST_CLEAR;
            MODE_SCAN:  nxt = ST_SCAN;
            default:    nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ram_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// ram_scan_ctrl_if
// Command / observation bundle of the RAM scan controller.
//   mode     [1:0]     command mode (manual / clear / scan / reserved)
//   start              single-cycle command pulse
//   wren               manual write enable (honoured only while idle)
//   addr_in  [ADDR_W]  manual address
//   data_in  [DATA_W]  manual write data
//   addr_out [ADDR_W]  address currently presented to the memory
//   data_out [DATA_W]  registered read data of the previous cycle's address
//   busy               high while clearing or scanning
//   done               one-cycle pulse on return to idle
// master: drives commands (user logic / bench); slave: the controller.
// -----------------------------------------------------------------------------
interface ram_scan_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
);

    logic [1:0]        mode;
    logic              start;
    logic              wren;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              busy;
    logic              done;

    modport master (
        output mode,
        output start,
        output wren,
        output addr_in,
        output data_in,
        input  addr_out,
        input  data_out,
        input  busy,
        input  done
    );

    modport slave (
        input  mode,
        input  start,
        input  wren,
        input  addr_in,
        input  data_in,
        output addr_out,
        output data_out,
        output busy,
        output done
    );

endinterface

// File: rtl/ram_sp.sv
// -----------------------------------------------------------------------------
// ram_sp
// Single-port synchronous RAM, 2**ADDR_W words of DATA_W bits.
// The read port is registered and reads before write: a write and a read of
// the same address on one edge return the old word.
//   clock   rising-edge clock
//   resetn  asynchronous active-low reset of the read register only; the
//           array itself is never cleared by reset
//   we      write enable
//   addr    shared read/write address
//   wdata   write data
//   rdata   registered read data
// -----------------------------------------------------------------------------
module ram_sp #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Non-blocking update of mem above means this samples the pre-write word.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rdata <= '0;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_scan_ctrl.sv
// -----------------------------------------------------------------------------
// ram_scan_ctrl
// Front-end controller for a small RAM. In IDLE the memory follows the manual
// address/data/write-enable inputs. A start pulse with mode=CLEAR zeroes every
// word, one per cycle. A start pulse with mode=SCAN steps the address through
// the whole memory once every TICK_DIV clocks, wrapping forever until another
// start pulse arrives. Display decoding of addr_out/data_out is done outside.
//   clock    sole clock, rising edge
//   resetn   asynchronous active-low reset (memory contents are kept)
//   bus      ram_scan_ctrl_if.slave: mode, start, wren, addr_in, data_in in;
//            addr_out, data_out, busy, done out
// Parameters: ADDR_W address width, DATA_W word width, TICK_DIV clocks per
// scan step (must be >= 2).
// -----------------------------------------------------------------------------
module ram_scan_ctrl
    import ram_scan_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 4,
    parameter int TICK_DIV = 50_000_000
) (
    input  logic           clock,
    input  logic           resetn,
    ram_scan_ctrl_if.slave bus
);

    localparam int                TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = '1;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [TICK_W-1:0] tick;
    logic              done_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // Memory port steering: manual inputs in IDLE, the sweep counter otherwise.
    // The clear sweep writes zero on every cycle it spends in CLEAR.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = bus.addr_in;
        mem_wdata = bus.data_in;
        case (state)
            ST_IDLE: begin
                mem_we = bus.wren;
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = '0;
            end
            default: begin
                mem_addr = cnt;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            tick   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Mode is only looked at here, alongside start.
                    if (bus.start) begin
                        state <= start_target(bus.mode);
                        cnt   <= '0;
                        tick  <= '0;
                    end
                end
                ST_CLEAR: begin
                    // start is deliberately ignored until the sweep finishes.
                    if (cnt == CNT_LAST) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                ST_SCAN: begin
                    if (bus.start) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        tick   <= '0;
                        done_q <= 1'b1;
                    end else if (tick == TICK_LAST) begin
                        tick <= '0;
                        // Natural overflow gives the DEPTH-1 -> 0 wrap.
                        cnt  <= cnt + ADDR_W'(1);
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    tick  <= '0;
                end
            endcase
        end
    end

    ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clock  (clock),
        .resetn (resetn),
        .we     (mem_we),
        .addr   (mem_addr),
        .wdata  (mem_wdata),
        .rdata  (bus.data_out)
    );

    assign bus.addr_out = mem_addr;
    // done is registered and only ever set on the edge that enters IDLE,
    // so it can never overlap busy.
    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = done_q;

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ram_scan_ctrl
// Scoreboard bench for ram_scan_ctrl (ADDR_W=5, DATA_W=4, TICK_DIV=4).
// Stimulus queues expected (cycle, signal, value) entries; a negedge monitor
// compares every entry due in the current cycle.
// -----------------------------------------------------------------------------
module tb_ram_scan_ctrl;

    localparam int AW = 5;
    localparam int DW = 4;
    localparam int TD = 4;

    localparam int SEL_DATA = 0;
    localparam int SEL_ADDR = 1;
    localparam int SEL_BUSY = 2;
    localparam int SEL_DONE = 3;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic  clk = 1'b0;
    logic  resetn;
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];

    ram_scan_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_scan_ctrl #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .TICK_DIV (TD)
    ) dut (
        .clock  (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            SEL_DATA: return 32'(bus.data_out);
            SEL_ADDR: return 32'(bus.addr_out);
            SEL_BUSY: return {31'b0, bus.busy};
            default:  return {31'b0, bus.done};
        endcase
    endfunction

    // Monitor: compare every queued expectation that falls due this cycle.
    always @(negedge clk) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due == cyc) begin
                logic [31:0] act;
                act = actual(exp_q[i].sel);
                checks++;
                if (act !== exp_q[i].val) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): got %0h, expected %0h",
                             exp_q[i].name, cyc, act, exp_q[i].val);
                end
                exp_q.delete(i);
            end else if (exp_q[i].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s: expectation for cycle %0d never sampled",
                         exp_q[i].name, exp_q[i].due);
                exp_q.delete(i);
            end
        end
    end

    task automatic expect_at(input int ofs, input int sel, input logic [31:0] val,
                             input string name);
        exp_t e;
        e.due  = cyc + ofs;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input int d);
        bus.wren    = 1'b1;
        bus.addr_in = AW'(a);
        bus.data_in = DW'(d);
        step();
        bus.wren    = 1'b0;
    endtask

    task automatic fill_all(input int d);
        for (int i = 0; i < 32; i++) write_word(i, d);
    endtask

    initial begin
        resetn      = 1'b0;
        bus.mode    = 2'b00;
        bus.start   = 1'b0;
        bus.wren    = 1'b0;
        bus.addr_in = 5'd9;
        bus.data_in = 4'd0;

        // Reset state
        step();
        expect_at(0, SEL_DATA, 0, "rst_data_out");
        expect_at(0, SEL_BUSY, 0, "rst_busy");
        expect_at(0, SEL_DONE, 0, "rst_done");
        expect_at(0, SEL_ADDR, 9, "rst_addr_out");
        step();
        resetn = 1'b1;
        step();

        // Manual write then read back
        bus.wren    = 1'b1;
        bus.addr_in = 5'd3;
        bus.data_in = 4'hA;
        expect_at(0, SEL_ADDR, 3, "man_addr_out");
        step();
        bus.wren = 1'b0;
        expect_at(1, SEL_DATA, 4'hA, "man_read");
        step();

        // Read during write returns old word first
        write_word(5, 2);
        bus.wren    = 1'b1;
        bus.data_in = 4'h9;
        expect_at(1, SEL_DATA, 4'h2, "rdw_old");
        step();
        bus.wren = 1'b0;
        expect_at(1, SEL_DATA, 4'h9, "rdw_new");
        step();

        // Ignored starts: reserved and manual mode
        bus.mode  = 2'b11;
        bus.start = 1'b1;
        expect_at(1, SEL_BUSY, 0, "rsvd_start_busy");
        step();
        bus.mode = 2'b00;
        expect_at(1, SEL_BUSY, 0, "manual_start_busy");
        step();
        bus.start = 1'b0;
        step();

        // Clear
        fill_all(15);
        bus.addr_in = 5'd7;
        bus.mode    = 2'b01;
        bus.start   = 1'b1;
        expect_at(0, SEL_BUSY, 0, "clr_busy_pre");
        for (int k = 1; k <= 32; k++) begin
            expect_at(k, SEL_BUSY, 1, "clr_busy");
            expect_at(k, SEL_ADDR, k - 1, "clr_addr");
        end
        expect_at(2,  SEL_DATA, 15, "clr_read_before_write");
        expect_at(16, SEL_DONE, 0,  "clr_done_mid");
        expect_at(33, SEL_DONE, 1,  "clr_done");
        expect_at(33, SEL_BUSY, 0,  "clr_busy_post");
        expect_at(34, SEL_DONE, 0,  "clr_done_once");
        step();
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        for (int k = 1; k <= 34; k++) begin
            if (k == 5) begin
                bus.start = 1'b1;
                bus.mode  = 2'b10;
            end
            step();
            bus.start = 1'b0;
            bus.mode  = 2'b00;
        end
        for (int i = 0; i < 32; i++) begin
            bus.addr_in = AW'(i);
            expect_at(1, SEL_DATA, 0, "clr_readback");
            step();
        end

        // Scan with a recognisable pattern in memory
        for (int i = 0; i < 32; i++) write_word(i, i % 16);
        bus.mode  = 2'b10;
        bus.start = 1'b1;
        for (int j = 0; j <= 32; j++) begin
            expect_at(1 + 4 * j, SEL_ADDR, j % 32, "scan_addr_first");
            expect_at(4 + 4 * j, SEL_ADDR, j % 32, "scan_addr_last");
            if (j < 32) expect_at(2 + 4 * j, SEL_DATA, j % 16, "scan_data");
        end
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 132; k++) begin
            if (k == 10) begin
                bus.wren    = 1'b1;
                bus.addr_in = 5'd0;
                bus.data_in = 4'h5;
                bus.mode    = 2'b01;
                expect_at(0, SEL_ADDR, 2, "scan_addr_ignores_addr_in");
            end
            step();
            bus.wren = 1'b0;
        end
        bus.mode  = 2'b00;
        bus.start = 1'b1;
        expect_at(0, SEL_BUSY, 1, "scan_busy_at_stop");
        expect_at(1, SEL_DONE, 1, "scan_done");
        expect_at(1, SEL_BUSY, 0, "scan_busy_post");
        expect_at(2, SEL_DONE, 0, "scan_done_once");
        step();
        bus.start   = 1'b0;
        bus.addr_in = 5'd0;
        expect_at(1, SEL_DATA, 0, "scan_wren_ignored");
        step();
        step();

        // Reset in the middle of a clear sweep
        fill_all(15);
        bus.mode  = 2'b01;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.mode  = 2'b00;
        for (int k = 0; k < 9; k++) step();
        expect_at(0, SEL_ADDR, 9, "rmc_pre_addr");
        step();
        resetn      = 1'b0;
        bus.addr_in = 5'd20;
        expect_at(0, SEL_BUSY, 0,  "rmc_busy");
        expect_at(0, SEL_DONE, 0,  "rmc_done");
        expect_at(0, SEL_DATA, 0,  "rmc_data");
        expect_at(0, SEL_ADDR, 20, "rmc_addr");
        step();
        step();
        resetn = 1'b1;
        expect_at(1, SEL_DONE, 0, "rmc_no_done");
        expect_at(1, SEL_BUSY, 0, "rmc_idle");
        step();
        for (int i = 0; i < 32; i++) begin
            bus.addr_in = AW'(i);
            expect_at(1, SEL_DATA, (i < 10) ? 0 : 15, "rmc_readback");
            step();
        end

        // Drain the scoreboard with a bounded wait
        for (int w = 0; w < 50 && exp_q.size() > 0; w++) step();
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_scan_ctrl.md
RAM_SCAN_CTRL -- requirements
Module: ram_scan_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 4, word width.
REQ-003 SHALL have parameter TICK_DIV, default 50_000_000, clocks per scan step; legal range >= 2.
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port mode  input  2  00 manual, 01 clear, 10 scan, 11 reserved.
REQ-007 SHALL have port start  input  1  single-cycle command pulse.
REQ-008 SHALL have port wren  input  1  manual write enable.
REQ-009 SHALL have port addr_in  input  ADDR_W  manual address.
REQ-010 SHALL have port data_in  input  DATA_W  manual write data.
REQ-011 SHALL have port addr_out  output  ADDR_W  address currently presented to the memory.
REQ-012 SHALL have port data_out  output  DATA_W  registered read data.
REQ-013 SHALL have port busy  output  1  high in CLEAR or SCAN.
REQ-014 SHALL have port done  output  1  one-cycle pulse at end of CLEAR or SCAN.

Function
REQ-015 SHALL contain a DEPTH x DATA_W single-port synchronous memory with read-before-write (same-address read returns old word).
REQ-016 SHALL implement FSM states IDLE, CLEAR, SCAN.
REQ-017 SHALL in IDLE drive addr_out = addr_in and write data_in to addr_in on any cycle with wren=1.
REQ-018 SHALL ignore wren outside IDLE.
REQ-019 SHALL update data_out one cycle after addr_out, from mem[addr_out], in every state.
REQ-020 SHALL go IDLE->CLEAR on start=1 with mode=01: address counter cnt starts at 0; write 0 to mem[cnt] each cycle; increment cnt.
REQ-021 SHALL leave CLEAR after writing address DEPTH-1 (exactly DEPTH cycles in CLEAR), pulse done the cycle IDLE is re-entered, and reset cnt to 0.
REQ-022 SHALL go IDLE->SCAN on start=1 with mode=10: cnt=0; tick counter counts 0..TICK_DIV-1; cnt increments when tick counter wraps.
REQ-023 SHALL wrap cnt from DEPTH-1 to 0 in SCAN and continue indefinitely.
REQ-024 SHALL leave SCAN on start=1 (any mode), pulse done the cycle IDLE is re-entered, and clear cnt and tick counter.
REQ-025 SHALL drive addr_out = cnt in CLEAR and SCAN.
REQ-026 SHALL ignore start in IDLE when mode is 00 or 11, and ignore start in CLEAR.
REQ-027 SHALL, when wren=1 and a valid start coincide in IDLE, perform the write and enter the new state in that same edge.
REQ-028 SHALL ignore mode changes after leaving IDLE; mode is sampled only with start.
REQ-029 SHALL assert busy combinationally from state; done SHALL NOT be asserted together with busy.

Reset
REQ-030 SHALL on resetn=0, immediately and regardless of state, force IDLE, cnt=0, tick counter=0, data_out=0, done=0, busy=0.
REQ-031 SHALL NOT clear memory contents on reset; a reset during CLEAR leaves a partial clear.
REQ-032 SHALL apply no done pulse on exit by reset.

Structure
REQ-033 SHALL place mode encodings and the FSM state enumeration in shared package ram_scan_pkg.
REQ-034 SHALL instantiate one sub-module ram_sp (parametrised ADDR_W, DATA_W single-port synchronous RAM); the FSM, counters, and muxes stay in ram_scan_ctrl.
REQ-035 SHALL leave seven-segment decoding outside this block; hex_decoder instances consume addr_out and data_out.

Verification
REQ-036 SHALL cover manual: write 0xA to addr 3, then addr_in=3, wren=0 -> data_out=0xA one cycle later.
REQ-037 SHALL cover clear: fill all 32 words with 0xF, start with mode=01 -> busy for 32 cycles, done pulse, all reads = 0.
REQ-038 SHALL cover scan (TICK_DIV=4): start with mode=10 -> addr_out 0,1,...,31,0 changing every 4 cycles; second start -> done, IDLE.
REQ-039 SHALL cover reset mid-CLEAR at cnt=10: addresses 0-9 = 0, 10-31 retain 0xF; busy=0, done=0.
REQ-040 SHALL cover ignored commands: start with mode=11 -> stays IDLE; wren during SCAN -> memory unchanged.
REQ-041 SHALL cover read-during-write: addr 5 holds 0x2, write 0x9 to addr 5 -> next data_out=0x2, following data_out=0x9.
